// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between two requesters, one operation in flight at a time.
// Define ALU_SHARE_RR_EN for round-robin arbitration; default build is fixed priority (requester 0 wins).
module alu_share_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_in1,
  input  logic [DATA_W-1:0] req0_in2,
  input  logic [3:0]        req0_cmd,
  input  logic              req0_s,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_in1,
  input  logic [DATA_W-1:0] req1_in2,
  input  logic [3:0]        req1_cmd,
  input  logic              req1_s,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [DATA_W-1:0] alu_c,
  output logic [3:0]        alu_cmd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_status,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_status,
  output logic [3:0]        sr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] in1_q, in1_d;
  logic [DATA_W-1:0] in2_q, in2_d;
  logic [3:0]        cmd_q, cmd_d;
  logic              s_q, s_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [3:0]        status_q, status_d;
  logic [3:0]        sr_q, sr_d;
  logic              grant1;
  logic              any_valid;
  logic              accept;

`ifdef ALU_SHARE_RR_EN
  logic ptr_q, ptr_d;

  // Requester 1 wins when alone, or when both are pending and the pointer favours it.
  assign grant1 = req1_valid && (!req0_valid || ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && any_valid) begin
      ptr_d = ~grant1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign grant1 = req1_valid && !req0_valid;
`endif

  assign any_valid  = req0_valid | req1_valid;
  assign accept     = (state_q == ST_IDLE) && any_valid && !rst;
  assign req0_ready = accept && !grant1;
  assign req1_ready = accept && grant1;

  always_comb begin
    state_d  = state_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    cmd_d    = cmd_q;
    s_d      = s_q;
    id_d     = id_q;
    result_d = result_q;
    status_d = status_q;
    sr_d     = sr_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d = ST_EXEC;
          id_d    = grant1;
          in1_d   = grant1 ? req1_in1 : req0_in1;
          in2_d   = grant1 ? req1_in2 : req0_in2;
          cmd_d   = grant1 ? req1_cmd : req0_cmd;
          s_d     = grant1 ? req1_s   : req0_s;
        end
      end
      ST_EXEC: begin
        state_d  = ST_RESP;
        result_d = alu_result;
        status_d = alu_status;
        if (s_q) begin
          sr_d = alu_status;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      in1_q    <= '0;
      in2_q    <= '0;
      cmd_q    <= '0;
      s_q      <= 1'b0;
      id_q     <= 1'b0;
      result_q <= '0;
      status_q <= '0;
      sr_q     <= '0;
    end else begin
      state_q  <= state_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      cmd_q    <= cmd_d;
      s_q      <= s_d;
      id_q     <= id_d;
      result_q <= result_d;
      status_q <= status_d;
      sr_q     <= sr_d;
    end
  end

  // The carry fed to the ALU is the live SR.C, so back-to-back ops see each other's flags.
  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_cmd    = cmd_q;
  assign alu_c      = {{(DATA_W-1){1'b0}}, sr_q[0]};
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_status = status_q;
  assign sr         = sr_q;

endmodule
